// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the fetch stage and its IF/ID register.
//   INSTR_WIDTH / IMM_WIDTH  : instruction word and immediate field widths
//   PC_STEP                  : byte distance between sequential instructions
//   RESET_PC                 : default PC after reset
//   IMM_MSB / IMM_LSB        : bounds of the immediate field inside the word
//   fetch_state_e            : fetch FSM states (F_HALT only with FETCH_MISALIGN_CHECK_EN)
package mips_pkg;
    localparam int          INSTR_WIDTH = 32;
    localparam int          IMM_WIDTH   = 16;
    localparam int          PC_STEP     = 4;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          IMM_MSB     = 15;
    localparam int          IMM_LSB     = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {F_REQ, F_WAIT, F_DRAIN, F_HALT} fetch_state_e;
`else
    typedef enum logic [1:0] {F_REQ, F_WAIT, F_DRAIN} fetch_state_e;
`endif
endpackage

// File: rtl/instr_fetch_ifid_reg.sv
// ifid_reg: valid/ready IF/ID holding register between fetch and decode.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load_i              : capture instr_i / pc_i and set valid
//   flush_i             : clear valid (highest priority)
//   deq_i               : decode consumed the held entry this cycle
//   instr_i, pc_i       : incoming instruction and its address
//   valid_o, instr_o,
//   pc_o, pc_plus4_o    : held entry
module ifid_reg
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  flush_i,
    input  logic                  deq_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o
);
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;

    // Flush beats load, and a load beats the dequeue of the old entry.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
            pc4_d   = pc_i + ADDR_WIDTH'(PC_STEP);
        end else if (deq_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc4_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage upstream of decode. Owns the PC, keeps at most one
// instruction-memory read outstanding and hands returned words to decode through
// the IF/ID register. Redirects flush the stage and discard in-flight data.
// Optional macro FETCH_MISALIGN_CHECK_EN: a redirect to a non-word-aligned PC sets
// the sticky fetch_misaligned output and halts fetching until reset.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/ready/addr        : memory read request channel
//   imem_rsp_valid/data              : memory read response
//   redirect_valid, redirect_pc      : branch/jump redirect
//   ifid_valid/ready                 : IF/ID handshake with decode
//   ifid_instr, ifid_pc,
//   ifid_pc_plus4, ifid_imm          : IF/ID payload
//   fetch_misaligned                 : (macro only) sticky misaligned-redirect flag
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(mips_pkg::RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  ifid_valid,
    input  logic                  ifid_ready,
    output logic [DATA_WIDTH-1:0] ifid_instr,
    output logic [ADDR_WIDTH-1:0] ifid_pc,
    output logic [ADDR_WIDTH-1:0] ifid_pc_plus4,
    output logic [IMM_WIDTH-1:0]  ifid_imm
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  fetch_misaligned
`endif
);
    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
    logic                  redirect_take;
    logic                  rsp_load;
    logic                  ifid_deq;

    assign redirect_pc_aligned = redirect_pc & ~ADDR_WIDTH'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;
    logic halt_now;
    // A halted stage ignores further redirects; only reset leaves F_HALT.
    assign halt_now         = redirect_valid && (state_q != F_HALT) && (redirect_pc[1:0] != 2'b00);
    assign redirect_take    = redirect_valid && (state_q != F_HALT) && !halt_now;
    assign fetch_misaligned = misaligned_q;
`else
    assign redirect_take    = redirect_valid;
`endif

    // Only request when the IF/ID slot is free or being drained this cycle, so the
    // response always lands in an empty register.
    assign imem_req_valid = !rst && (state_q == F_REQ) && !redirect_valid
                            && (!ifid_valid || ifid_ready);
    assign imem_req_addr  = pc_q;

    assign rsp_load = (state_q == F_WAIT) && imem_rsp_valid && !redirect_valid;
    assign ifid_deq = ifid_valid && ifid_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= F_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q <= 1'b0;
        end else if (halt_now) begin
            misaligned_q <= 1'b1;
            state_q      <= F_HALT;
`endif
        end else if (redirect_take) begin
            pc_q <= redirect_pc_aligned;
            // A request still in flight must have its response swallowed.
            if (state_q == F_WAIT) begin
                state_q <= imem_rsp_valid ? F_REQ : F_DRAIN;
            end
        end else begin
            case (state_q)
                F_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + ADDR_WIDTH'(PC_STEP);
                        state_q  <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (imem_rsp_valid) state_q <= F_REQ;
                end
                F_DRAIN: begin
                    if (imem_rsp_valid) state_q <= F_REQ;
                end
                default: state_q <= state_q;
            endcase
        end
    end

    ifid_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (rsp_load),
        .flush_i   (redirect_valid),
        .deq_i     (ifid_deq),
        .instr_i   (imem_rsp_data),
        .pc_i      (req_pc_q),
        .valid_o   (ifid_valid),
        .instr_o   (ifid_instr),
        .pc_o      (ifid_pc),
        .pc_plus4_o(ifid_pc_plus4)
    );

    assign ifid_imm = ifid_instr[IMM_MSB:IMM_LSB];
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of decode.
- Owns the PC and issues one instruction-memory read at a time.
- Captures each returned word into an IF/ID output register with a valid/ready handshake.
- Decode consumes ifid_instr. ifid_imm (instr[15:0]) feeds the decode-stage 16→32 immediate sign extender.
- Branch/jump redirects flush the stage and discard any in-flight response.

Parameters:
- ADDR_WIDTH, 32: PC and memory address width.
- DATA_WIDTH, 32: instruction word width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  read address (= pc).
- imem_rsp_valid  in  1  read data valid; at most one per accepted request.
- imem_rsp_data  in  DATA_WIDTH  instruction word.
- redirect_valid  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  ADDR_WIDTH  new PC.
- ifid_valid  out  1  IF/ID register holds an instruction.
- ifid_ready  in  1  decode accepts this cycle.
- ifid_instr  out  DATA_WIDTH  fetched instruction.
- ifid_pc  out  ADDR_WIDTH  address of ifid_instr.
- ifid_pc_plus4  out  ADDR_WIDTH  ifid_pc + 4.
- ifid_imm  out  16  ifid_instr[15:0], input to the sign extender.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pc = RESET_PC; state = F_REQ.
  - ifid_valid = 0; ifid_instr, ifid_pc, ifid_pc_plus4 = 0.
  - imem_req_valid = 0 during the reset cycle.
- Reset mid-operation: any in-flight response is ignored. Memory must also be reset by the same rst.
- States:
  - F_REQ: may issue a request.
  - F_WAIT: one request outstanding.
  - F_DRAIN: one stale request outstanding; its response is discarded.
- F_REQ:
  - imem_req_valid = !redirect_valid && (!ifid_valid || ifid_ready).
  - imem_req_addr = pc.
  - The request may deassert before acceptance; memory samples only on valid && ready.
  - On valid && ready: req_pc <= pc; pc <= pc + 4 (modulo 2^ADDR_WIDTH, wraps silently); go to F_WAIT.
- F_WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid: ifid_valid <= 1; ifid_instr <= data; ifid_pc <= req_pc; ifid_pc_plus4 <= req_pc + 4; go to F_REQ.
  - The IF/ID register is guaranteed empty here, because a request is only issued when the register is empty or being dequeued.
- F_DRAIN:
  - imem_req_valid = 0.
  - On imem_rsp_valid: drop the data; go to F_REQ.
- Redirect (highest priority, any state):
  - pc <= redirect_pc; ifid_valid <= 0, even if ifid_ready is low.
  - No request is issued that cycle.
  - F_WAIT with no response this cycle → F_DRAIN.
  - F_WAIT with a response this cycle → drop the response; go to F_REQ.
  - F_DRAIN → stays F_DRAIN.
  - F_REQ → stays F_REQ.
- Output handshake:
  - ifid_valid && ifid_ready clears ifid_valid, unless a new response loads it in the same cycle. A load wins over the clear.
  - IF/ID outputs are held stable while ifid_valid && !ifid_ready.
- Latency and throughput:
  - Minimum request-to-ifid_valid latency is 1 cycle after the response.
  - Peak throughput is one instruction per 2 cycles with zero-wait memory (single outstanding request).
- ifid_imm is purely combinational from ifid_instr.
- Redirect alignment: redirect_pc[1:0] is forced to 0 before loading the PC.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 sets fetch_misaligned sticky and does not load the PC.
  - The stage then enters F_HALT: no further requests; any outstanding response is dropped. Only rst exits.
- Undefined:
  - No port and no F_HALT state.
  - Low PC bits are silently forced to 0.

Decomposition:
- Shared package mips_pkg holds:
  - INSTR_WIDTH = 32, IMM_WIDTH = 16, PC_STEP = 4, RESET_PC.
  - Immediate field bounds IMM_MSB = 15, IMM_LSB = 0.
  - Fetch state enum {F_REQ, F_WAIT, F_DRAIN, F_HALT}.
- One sub-module: ifid_reg, the valid/ready IF/ID holding register with load, dequeue and flush inputs.
- PC and state logic stay in instr_fetch.

Test Plan:
- Reset, then zero-wait memory returning 32'h2008_FFFC at 0x0 and 32'h2109_0010 at 0x4 → requests at 0x0 then 0x4. ifid_instr/ifid_pc = 2008_FFFC/0x0, then 2109_0010/0x4. ifid_imm = FFFC then 0010. ifid_pc_plus4 = 0x4 then 0x8.
- ifid_ready held low 5 cycles with ifid_valid high → no new request issued; outputs stable; resumes one cycle after ready rises.
- Redirect to 0x0040_0100 while in F_WAIT, response arriving 3 cycles later → that response is dropped; ifid_valid stays 0; next request address is 0x0040_0100.
- Redirect in the same cycle as imem_rsp_valid → response dropped; no request that cycle; next request is to the redirect target.
- PC = 0xFFFF_FFFC fetch → next request address 0x0000_0000.
- FETCH_MISALIGN_CHECK_EN defined, redirect_pc = 0x102 → fetch_misaligned = 1 and no further requests until rst. Macro undefined, same stimulus → next request at 0x100.
